// File: rtl/r_ram_to_uart.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : r_ram_to_uart
//  Description : Reads a block of FULL_NUMBER bytes from a synchronous RAM,
//                one byte at a time, and sends each byte as an 8N1 UART frame.
//                One block is sent per assertion of the level start input.
//                The end flag stays high until start is released.
//  Revision    : 1.0  initial release
// ============================================================================
module r_ram_to_uart #(
    parameter int CLK_FREQ    = 50000000,  // system clock frequency in Hz
    parameter int BAUD        = 115200,    // UART bit rate
    parameter int FULL_NUMBER = 8864,      // bytes per block, 1..32768
    parameter int RD_LAT      = 2          // RAM read latency, 1..4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        r_ram_to_uart_start,
    input  logic [7:0]  ram_dout,
    output logic [14:0] address,
    output logic        ram_en,
    output logic        uart_txd,
    output logic        busy,
    output logic        r_ram_to_uart_end
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int BIT_CYCLES = CLK_FREQ / BAUD;
    // A one-clock bit period still needs a 1-bit counter to stay legal.
    localparam int BCNT_W     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [BCNT_W-1:0] C_BIT_LAST  = BCNT_W'(BIT_CYCLES - 1);
    localparam logic [BCNT_W-1:0] C_BCNT_ONE  = BCNT_W'(1);
    localparam logic [14:0]       C_ADDR_LAST = 15'(FULL_NUMBER - 1);
    localparam logic [1:0]        C_WAIT_LAST = 2'(RD_LAT - 1);
    // Frame bit index: 0 = start bit, 1..8 = data bits, 9 = stop bit.
    localparam logic [3:0]        C_LAST_DATA = 4'd8;
    localparam logic [3:0]        C_STOP_BIT  = 4'd9;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_TX   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              state_q;
    logic [14:0]         cnt_q;      // byte counter, doubles as RAM address
    logic [7:0]          shift_q;    // data bits still to be shifted out
    logic [BCNT_W-1:0]   baud_q;     // clocks elapsed in the current bit
    logic [3:0]          bit_q;      // position within the frame
    logic [1:0]          wait_q;     // RAM latency counter
    logic                txd_q;
    logic                ram_en_q;
    logic                busy_q;
    logic                end_q;

    logic                w_bit_end;   // last clock of the current serial bit
    logic                w_last_byte; // current byte is the final one of the block

    // Decode the end-of-bit and end-of-block conditions used by the FSM.
    always_comb begin
        w_bit_end   = (baud_q == C_BIT_LAST);
        w_last_byte = (cnt_q == C_ADDR_LAST);
    end

    // Main controller: RAM fetch, latency wait, frame serialisation, handshake.
    // All outputs are registered here so the serial line never glitches.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            baud_q   <= '0;
            bit_q    <= '0;
            wait_q   <= '0;
            txd_q    <= 1'b1;
            ram_en_q <= 1'b0;
            busy_q   <= 1'b0;
            end_q    <= 1'b0;
        end else begin
            // ram_en is a single-cycle strobe; it is re-armed only on entry to RD.
            ram_en_q <= 1'b0;

            // Releasing start clears the end flag in every state; DONE below
            // takes priority so a short start pulse still produces an end pulse.
            if (!r_ram_to_uart_start) begin
                end_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (r_ram_to_uart_start && !end_q && !busy_q) begin
                        state_q  <= S_RD;
                        busy_q   <= 1'b1;
                        ram_en_q <= 1'b1;
                    end
                end

                S_RD: begin
                    state_q <= S_WAIT;
                    wait_q  <= '0;
                end

                S_WAIT: begin
                    if (wait_q == C_WAIT_LAST) begin
                        // Read data is valid on this, the last latency cycle.
                        shift_q <= ram_dout;
                        state_q <= S_TX;
                        txd_q   <= 1'b0;   // start bit
                        baud_q  <= '0;
                        bit_q   <= '0;
                    end else begin
                        wait_q <= wait_q + 2'd1;
                    end
                end

                S_TX: begin
                    if (w_bit_end) begin
                        baud_q <= '0;
                        if (bit_q == C_STOP_BIT) begin
                            if (w_last_byte) begin
                                state_q <= S_DONE;
                            end else begin
                                // Fetch the next byte straight away, no idle gap.
                                cnt_q    <= cnt_q + 15'd1;
                                state_q  <= S_RD;
                                ram_en_q <= 1'b1;
                            end
                        end else begin
                            bit_q <= bit_q + 4'd1;
                            if (bit_q == C_LAST_DATA) begin
                                txd_q <= 1'b1;   // stop bit
                            end else begin
                                txd_q   <= shift_q[0];
                                shift_q <= {1'b0, shift_q[7:1]};
                            end
                        end
                    end else begin
                        baud_q <= baud_q + C_BCNT_ONE;
                    end
                end

                S_DONE: begin
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    end_q   <= 1'b1;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign address           = cnt_q;
    assign ram_en            = ram_en_q;
    assign uart_txd          = txd_q;
    assign busy              = busy_q;
    assign r_ram_to_uart_end = end_q;

endmodule
`default_nettype wire

// File: doc/r_ram_to_uart.md
R_RAM_TO_UART -- requirements
Module: r_ram_to_uart

Interface
- REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
- REQ-002 SHALL have parameter BAUD, default 115200, UART bit rate.
- REQ-003 SHALL have parameter FULL_NUMBER, default 8864 (0x22A0), bytes per transfer; legal range 1..32768.
- REQ-004 SHALL have parameter RD_LAT, default 2, RAM read latency in cycles; legal range 1..4.
- REQ-005 SHALL have port sys_clk  input  1  single clock; all logic on its rising edge.
- REQ-006 SHALL have port sys_rst_n  input  1  asynchronous, active-low reset.
- REQ-007 SHALL have port r_ram_to_uart_start  input  1  level request to send one block.
- REQ-008 SHALL have port ram_dout  input  8  RAM read data, valid RD_LAT cycles after the ram_en cycle.
- REQ-009 SHALL have port address  output  15  RAM read address, equal to the byte counter.
- REQ-010 SHALL have port ram_en  output  1  RAM read enable, one-cycle pulse per byte.
- REQ-011 SHALL have port uart_txd  output  1  serial line, idle high.
- REQ-012 SHALL have port busy  output  1  high while a block transfer is in progress.
- REQ-013 SHALL have port r_ram_to_uart_end  output  1  block-complete flag, held until start is low.

Function
- REQ-014 SHALL define BIT_CYCLES = CLK_FREQ/BAUD (integer division); every serial bit lasts exactly BIT_CYCLES clocks.
- REQ-015 SHALL send each byte as an 8N1 frame: start bit 0, data bits LSB first, stop bit 1, for 10*BIT_CYCLES clocks in total.
- REQ-016 SHALL implement the states IDLE, RD, WAIT, TX and DONE.
- REQ-017 IDLE: SHALL go to RD when start=1, end=0 and busy=0; otherwise it SHALL remain in IDLE.
- REQ-018 RD: ram_en=1 for exactly one cycle with address=counter; next state is WAIT.
- REQ-019 WAIT: SHALL count RD_LAT cycles, latch ram_dout into the shift register on the last count, and then go to TX.
- REQ-020 TX: uart_txd SHALL drop to 0 on the first TX cycle and SHALL be driven from a registered output (glitch-free).
- REQ-021 After the stop bit completes, the block SHALL go to DONE if counter == FULL_NUMBER-1.
- REQ-022 After the stop bit completes with counter != FULL_NUMBER-1, the block SHALL increment counter and go to RD, with no idle gap beyond the RD and WAIT cycles.
- REQ-023 DONE: SHALL set counter<=0, busy<=0 and end<=1, and go to IDLE, all in one cycle.
- REQ-024 busy SHALL be 1 from the cycle after IDLE accepts start until DONE.
- REQ-025 start SHALL be sampled only in IDLE; deasserting start mid-block SHALL NOT abort the block, and all FULL_NUMBER bytes SHALL still be sent.
- REQ-026 end SHALL clear on the cycle after any cycle in which start=0, in any state.
- REQ-027 While end=1 and start stays high, no new transfer SHALL begin; this gives one block per start assertion.
- REQ-028 The counter SHALL be 15 bits; address SHALL never exceed FULL_NUMBER-1 during a transfer.
- REQ-029 FULL_NUMBER=1 SHALL send exactly one frame (address 0) and then assert end.
- REQ-030 The bit-period counter SHALL be $clog2(BIT_CYCLES) bits wide; ram_en SHALL be 0 in every state except RD.

Reset
- REQ-031 While sys_rst_n=0, the outputs SHALL be: uart_txd=1, address=0, ram_en=0, busy=0, end=0.
- REQ-032 While sys_rst_n=0, the state SHALL be IDLE and the shift register and bit counters SHALL be 0.
- REQ-033 Reset asserted mid-frame SHALL force uart_txd high immediately (asynchronously); the partial frame is abandoned.
- REQ-034 After reset release, the next transfer SHALL start at address 0.

Verification
- REQ-035 Reset check: apply reset, then release with start=0 -> uart_txd=1, address=0, busy=0, end=0, and no ram_en for 100 cycles.
- REQ-036 Basic block (CLK_FREQ=16, BAUD=1, FULL_NUMBER=4, RD_LAT=2; RAM holds A5,3C,00,FF; start=1) -> exactly four frames decoded as A5,3C,00,FF.
- REQ-037 Basic block timing -> each bit lasts 16 cycles, end rises on the cycle after the last stop bit ends, and address returns to 0.
- REQ-038 Level handshake: hold start=1 for 2000 cycles after end -> no extra frame; drop start -> end=0 next cycle; raise start again -> the block resends from address 0.
- REQ-039 One-cycle start pulse with FULL_NUMBER=4 -> all four frames are still sent; end rises, then clears one cycle later because start is already 0.
- REQ-040 Reset during the data bits of byte 2 -> uart_txd=1 at once and address=0; the next start sends bytes starting from A5.
- REQ-041 FULL_NUMBER=1 with RAM[0]=5A -> a single frame 0,0,1,0,1,1,0,1,0,1 (start bit, LSB-first data, stop bit), then end=1 and busy=0.
